// File: rtl/instruction_decode.sv
// Instruction decode stage: register file with write-through read, MIPS-subset
// decoder, hazard detection, branch/jump redirect and the ID/EX pipeline register.
module instruction_decode (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instruction_in,
    input  logic [31:0] PC_add_four_in,
    input  logic        wb_reg_write,
    input  logic [4:0]  wb_write_addr,
    input  logic [31:0] wb_write_data,
    input  logic        ex_reg_write,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_dest_addr,
    input  logic        mem_reg_write,
    input  logic [4:0]  mem_dest_addr,
    output logic        PC_mux_sel,
    output logic [31:0] PC_jump,
    output logic        stall,
    output logic [31:0] rs_data_out,
    output logic [31:0] rt_data_out,
    output logic [31:0] imm_out,
    output logic [31:0] PC_add_four_out,
    output logic [4:0]  rs_addr_out,
    output logic [4:0]  rt_addr_out,
    output logic [4:0]  dest_addr_out,
    output logic [3:0]  alu_op_out,
    output logic        alu_src_out,
    output logic        mem_read_out,
    output logic        mem_write_out,
    output logic        reg_write_out,
    output logic        link_out
);

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR  = 4'd3, ALU_XOR = 4'd4,
        ALU_SLT = 4'd5, ALU_SLL = 4'd6, ALU_SRL = 4'd7, ALU_LUI = 4'd8
    } alu_op_t;

    localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_JAL  = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04, OP_BNE  = 6'h05, OP_ADDI = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09, OP_ANDI = 6'h0C, OP_ORI  = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F, OP_LW   = 6'h23, OP_SW   = 6'h2B;

    localparam logic [5:0] F_SLL = 6'h00, F_SRL = 6'h02, F_JR  = 6'h08;
    localparam logic [5:0] F_ADD = 6'h20, F_ADDU = 6'h21, F_SUB = 6'h22, F_SUBU = 6'h23;
    localparam logic [5:0] F_AND = 6'h24, F_OR  = 6'h25, F_XOR = 6'h26, F_SLT  = 6'h2A;

    logic [31:0] regs [32];

    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [15:0] imm16;
    logic [31:0] sext_imm, zext_imm, rs_data, rt_data;

    alu_op_t     d_alu_op;
    logic        d_alu_src, d_mem_read, d_mem_write, d_reg_write, d_link;
    logic [4:0]  d_dest;
    logic [31:0] d_imm;
    logic        is_beq, is_bne, is_jump, is_jr, reads_rt;
    logic        load_use, ex_hit, mem_hit, br_rs, br_rt;

    assign opcode   = instruction_in[31:26];
    assign rs       = instruction_in[25:21];
    assign rt       = instruction_in[20:16];
    assign rd       = instruction_in[15:11];
    assign shamt    = instruction_in[10:6];
    assign funct    = instruction_in[5:0];
    assign imm16    = instruction_in[15:0];
    assign sext_imm = {{16{imm16[15]}}, imm16};
    assign zext_imm = {16'h0000, imm16};

    // Register reads see a same-cycle writeback so WB->ID needs no extra stall
    assign rs_data = (rs == 5'd0) ? 32'd0 :
                     (wb_reg_write && wb_write_addr == rs) ? wb_write_data : regs[rs];
    assign rt_data = (rt == 5'd0) ? 32'd0 :
                     (wb_reg_write && wb_write_addr == rt) ? wb_write_data : regs[rt];

    // Register file write port; reset wins over a coincident writeback
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
        end else if (wb_reg_write && wb_write_addr != 5'd0) begin
            regs[wb_write_addr] <= wb_write_data;
        end
    end

    // Decode control fields; an all-zero word is a flush bubble, not sll $0
    always_comb begin
        d_alu_op    = ALU_ADD;
        d_alu_src   = 1'b0;
        d_mem_read  = 1'b0;
        d_mem_write = 1'b0;
        d_reg_write = 1'b0;
        d_link      = 1'b0;
        d_dest      = 5'd0;
        d_imm       = 32'd0;
        is_beq      = 1'b0;
        is_bne      = 1'b0;
        is_jump     = 1'b0;
        is_jr       = 1'b0;
        reads_rt    = 1'b0;
        if (instruction_in != 32'd0) begin
            case (opcode)
                OP_RTYPE: begin
                    d_dest      = rd;
                    d_reg_write = 1'b1;
                    reads_rt    = 1'b1;
                    case (funct)
                        F_ADD, F_ADDU: d_alu_op = ALU_ADD;
                        F_SUB, F_SUBU: d_alu_op = ALU_SUB;
                        F_AND:         d_alu_op = ALU_AND;
                        F_OR:          d_alu_op = ALU_OR;
                        F_XOR:         d_alu_op = ALU_XOR;
                        F_SLT:         d_alu_op = ALU_SLT;
                        F_SLL, F_SRL: begin
                            d_alu_op  = (funct == F_SLL) ? ALU_SLL : ALU_SRL;
                            d_alu_src = 1'b1;
                            d_imm     = {27'd0, shamt};
                        end
                        F_JR: begin
                            is_jr       = 1'b1;
                            d_dest      = 5'd0;
                            d_reg_write = 1'b0;
                            reads_rt    = 1'b0;
                        end
                        default: begin
                            d_dest      = 5'd0;
                            d_reg_write = 1'b0;
                            reads_rt    = 1'b0;
                        end
                    endcase
                end
                OP_ADDI, OP_ADDIU: begin
                    d_alu_src = 1'b1; d_imm = sext_imm; d_dest = rt; d_reg_write = 1'b1;
                end
                OP_ANDI: begin
                    d_alu_op = ALU_AND; d_alu_src = 1'b1; d_imm = zext_imm;
                    d_dest = rt; d_reg_write = 1'b1;
                end
                OP_ORI: begin
                    d_alu_op = ALU_OR; d_alu_src = 1'b1; d_imm = zext_imm;
                    d_dest = rt; d_reg_write = 1'b1;
                end
                OP_LUI: begin
                    d_alu_op = ALU_LUI; d_alu_src = 1'b1; d_imm = {imm16, 16'h0000};
                    d_dest = rt; d_reg_write = 1'b1;
                end
                OP_LW: begin
                    d_alu_src = 1'b1; d_imm = sext_imm; d_mem_read = 1'b1;
                    d_dest = rt; d_reg_write = 1'b1;
                end
                OP_SW: begin
                    d_alu_src = 1'b1; d_imm = sext_imm; d_mem_write = 1'b1; reads_rt = 1'b1;
                end
                OP_BEQ: begin
                    is_beq = 1'b1; d_alu_op = ALU_SUB; d_imm = sext_imm; reads_rt = 1'b1;
                end
                OP_BNE: begin
                    is_bne = 1'b1; d_alu_op = ALU_SUB; d_imm = sext_imm; reads_rt = 1'b1;
                end
                OP_J: is_jump = 1'b1;
                OP_JAL: begin
                    is_jump = 1'b1; d_link = 1'b1; d_dest = 5'd31; d_reg_write = 1'b1;
                end
                default: ;
            endcase
        end
        if (d_dest == 5'd0) d_reg_write = 1'b0;
    end

    // Hazards: load-use, and branch/jr operands still in flight in EX or MEM
    always_comb begin
        br_rs    = is_beq | is_bne | is_jr;
        br_rt    = is_beq | is_bne;
        load_use = ex_mem_read && (ex_dest_addr != 5'd0) &&
                   ((ex_dest_addr == rs) || (reads_rt && ex_dest_addr == rt));
        ex_hit   = ex_reg_write && (ex_dest_addr != 5'd0) &&
                   ((br_rs && ex_dest_addr == rs) || (br_rt && ex_dest_addr == rt));
        mem_hit  = mem_reg_write && (mem_dest_addr != 5'd0) &&
                   ((br_rs && mem_dest_addr == rs) || (br_rt && mem_dest_addr == rt));
        stall    = load_use | ex_hit | mem_hit;
    end

    // Redirect fetch for taken branches and jumps, suppressed while stalled
    always_comb begin
        PC_mux_sel = 1'b0;
        PC_jump    = 32'd0;
        if (!stall) begin
            if ((is_beq && rs_data == rt_data) || (is_bne && rs_data != rt_data)) begin
                PC_mux_sel = 1'b1;
                PC_jump    = PC_add_four_in + {sext_imm[29:0], 2'b00};
            end else if (is_jump) begin
                PC_mux_sel = 1'b1;
                PC_jump    = {PC_add_four_in[31:28], instruction_in[25:0], 2'b00};
            end else if (is_jr) begin
                PC_mux_sel = 1'b1;
                PC_jump    = rs_data;
            end
        end
    end

    // ID/EX pipeline register: cleared on reset, bubble on stall, else decoded fields
    always_ff @(posedge clk) begin
        if (rst || stall) begin
            rs_data_out     <= 32'd0;
            rt_data_out     <= 32'd0;
            imm_out         <= 32'd0;
            PC_add_four_out <= 32'd0;
            rs_addr_out     <= 5'd0;
            rt_addr_out     <= 5'd0;
            dest_addr_out   <= 5'd0;
            alu_op_out      <= 4'd0;
            alu_src_out     <= 1'b0;
            mem_read_out    <= 1'b0;
            mem_write_out   <= 1'b0;
            reg_write_out   <= 1'b0;
            link_out        <= 1'b0;
        end else begin
            rs_data_out     <= rs_data;
            rt_data_out     <= rt_data;
            imm_out         <= d_imm;
            PC_add_four_out <= PC_add_four_in;
            rs_addr_out     <= rs;
            rt_addr_out     <= rt;
            dest_addr_out   <= d_dest;
            alu_op_out      <= d_alu_op;
            alu_src_out     <= d_alu_src;
            mem_read_out    <= d_mem_read;
            mem_write_out   <= d_mem_write;
            reg_write_out   <= d_reg_write;
            link_out        <= d_link;
        end
    end

endmodule

// File: tb/tb_instruction_decode.sv
// Directed testbench for instruction_decode: hand-encoded instructions with
// hand-computed expected outputs, checked with immediate assertions.
module tb_instruction_decode;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instruction_in, PC_add_four_in;
    logic        wb_reg_write;
    logic [4:0]  wb_write_addr;
    logic [31:0] wb_write_data;
    logic        ex_reg_write, ex_mem_read, mem_reg_write;
    logic [4:0]  ex_dest_addr, mem_dest_addr;
    logic        PC_mux_sel, stall;
    logic [31:0] PC_jump;
    logic [31:0] rs_data_out, rt_data_out, imm_out, PC_add_four_out;
    logic [4:0]  rs_addr_out, rt_addr_out, dest_addr_out;
    logic [3:0]  alu_op_out;
    logic        alu_src_out, mem_read_out, mem_write_out, reg_write_out, link_out;

    int checks   = 0;
    int failures = 0;

    instruction_decode dut (
        .clk(clk), .rst(rst),
        .instruction_in(instruction_in), .PC_add_four_in(PC_add_four_in),
        .wb_reg_write(wb_reg_write), .wb_write_addr(wb_write_addr), .wb_write_data(wb_write_data),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_dest_addr(ex_dest_addr),
        .mem_reg_write(mem_reg_write), .mem_dest_addr(mem_dest_addr),
        .PC_mux_sel(PC_mux_sel), .PC_jump(PC_jump), .stall(stall),
        .rs_data_out(rs_data_out), .rt_data_out(rt_data_out), .imm_out(imm_out),
        .PC_add_four_out(PC_add_four_out), .rs_addr_out(rs_addr_out), .rt_addr_out(rt_addr_out),
        .dest_addr_out(dest_addr_out), .alu_op_out(alu_op_out), .alu_src_out(alu_src_out),
        .mem_read_out(mem_read_out), .mem_write_out(mem_write_out),
        .reg_write_out(reg_write_out), .link_out(link_out)
    );

    // Free-running clock, 10 time-unit period
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] instr, input logic [31:0] pc4);
        instruction_in = instr;
        PC_add_four_in = pc4;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic writeback(input logic en, input logic [4:0] addr, input logic [31:0] data);
        wb_reg_write  = en;
        wb_write_addr = addr;
        wb_write_data = data;
    endtask

    // Linear sequence of directed steps
    initial begin
        rst = 1'b1;
        instruction_in = 32'd0; PC_add_four_in = 32'd0;
        writeback(1'b0, 5'd0, 32'd0);
        ex_reg_write = 1'b0; ex_mem_read = 1'b0; ex_dest_addr = 5'd0;
        mem_reg_write = 1'b0; mem_dest_addr = 5'd0;
        @(negedge clk);
        tick();
        rst = 1'b0;

        // Reset state with a nop word
        applyStimulus(32'h0000_0000, 32'h0);
        checkOutput("rst_stall", {31'd0, stall}, 32'd0);
        checkOutput("rst_pcsel", {31'd0, PC_mux_sel}, 32'd0);
        checkOutput("rst_pcjump", PC_jump, 32'd0);
        tick();
        checkOutput("nop_rs_data", rs_data_out, 32'd0);
        checkOutput("nop_regwrite", {31'd0, reg_write_out}, 32'd0);
        checkOutput("nop_aluop", {28'd0, alu_op_out}, 32'd0);
        checkOutput("nop_alusrc", {31'd0, alu_src_out}, 32'd0);
        checkOutput("nop_imm", imm_out, 32'd0);

        // Writeback of $5 bypassed into same-cycle add $3,$5,$0
        writeback(1'b1, 5'd5, 32'h1234_5678);
        applyStimulus(32'h00A0_1820, 32'h40);
        tick();
        writeback(1'b0, 5'd0, 32'd0);
        checkOutput("add_rs_bypass", rs_data_out, 32'h1234_5678);
        checkOutput("add_aluop", {28'd0, alu_op_out}, 32'd0);
        checkOutput("add_dest", {27'd0, dest_addr_out}, 32'd3);
        checkOutput("add_regwrite", {31'd0, reg_write_out}, 32'd1);
        checkOutput("add_rs_addr", {27'd0, rs_addr_out}, 32'd5);
        checkOutput("add_pc4", PC_add_four_out, 32'h40);

        // $1 = $2 = 7, then branches
        writeback(1'b1, 5'd1, 32'd7);
        applyStimulus(32'h0, 32'h0);
        tick();
        writeback(1'b1, 5'd2, 32'd7);
        tick();
        writeback(1'b0, 5'd0, 32'd0);
        applyStimulus(32'h1022_0003, 32'h100);
        checkOutput("beq_pcsel", {31'd0, PC_mux_sel}, 32'd1);
        checkOutput("beq_pcjump", PC_jump, 32'h10C);
        checkOutput("beq_stall", {31'd0, stall}, 32'd0);
        tick();
        checkOutput("beq_imm", imm_out, 32'd3);
        checkOutput("beq_regwrite", {31'd0, reg_write_out}, 32'd0);
        applyStimulus(32'h1422_0003, 32'h100);
        checkOutput("bne_pcsel", {31'd0, PC_mux_sel}, 32'd0);
        checkOutput("bne_pcjump", PC_jump, 32'd0);
        applyStimulus(32'h1022_FFFF, 32'h100);
        checkOutput("beq_back_pcjump", PC_jump, 32'h0FC);
        tick();
        checkOutput("beq_back_imm", imm_out, 32'hFFFF_FFFF);

        // Branch operand still being produced in EX, then in MEM
        ex_reg_write = 1'b1; ex_dest_addr = 5'd2;
        applyStimulus(32'h1022_0003, 32'h100);
        checkOutput("br_ex_stall", {31'd0, stall}, 32'd1);
        checkOutput("br_ex_pcsel", {31'd0, PC_mux_sel}, 32'd0);
        ex_reg_write = 1'b0; ex_dest_addr = 5'd0;
        mem_reg_write = 1'b1; mem_dest_addr = 5'd1;
        applyStimulus(32'h1022_0003, 32'h100);
        checkOutput("br_mem_stall", {31'd0, stall}, 32'd1);
        mem_reg_write = 1'b0; mem_dest_addr = 5'd0;
        applyStimulus(32'h1022_0003, 32'h100);
        checkOutput("br_clear_stall", {31'd0, stall}, 32'd0);

        // Load-use on add $6,$4,$4: bubble, then the add on release
        ex_mem_read = 1'b1; ex_dest_addr = 5'd4;
        applyStimulus(32'h0084_3020, 32'h200);
        checkOutput("lu_stall", {31'd0, stall}, 32'd1);
        tick();
        checkOutput("lu_bubble_regwrite", {31'd0, reg_write_out}, 32'd0);
        checkOutput("lu_bubble_dest", {27'd0, dest_addr_out}, 32'd0);
        checkOutput("lu_bubble_rsaddr", {27'd0, rs_addr_out}, 32'd0);
        checkOutput("lu_bubble_pc4", PC_add_four_out, 32'd0);
        ex_mem_read = 1'b0; ex_dest_addr = 5'd0;
        applyStimulus(32'h0084_3020, 32'h200);
        checkOutput("lu_release_stall", {31'd0, stall}, 32'd0);
        tick();
        checkOutput("lu_add_dest", {27'd0, dest_addr_out}, 32'd6);
        checkOutput("lu_add_regwrite", {31'd0, reg_write_out}, 32'd1);
        checkOutput("lu_add_rtaddr", {27'd0, rt_addr_out}, 32'd4);

        // jal keeps upper PC bits
        applyStimulus(32'h0C00_0040, 32'h8000_0010);
        checkOutput("jal_pcsel", {31'd0, PC_mux_sel}, 32'd1);
        checkOutput("jal_pcjump", PC_jump, 32'h8000_0100);
        tick();
        checkOutput("jal_link", {31'd0, link_out}, 32'd1);
        checkOutput("jal_dest", {27'd0, dest_addr_out}, 32'd31);
        checkOutput("jal_regwrite", {31'd0, reg_write_out}, 32'd1);
        checkOutput("jal_pc4", PC_add_four_out, 32'h8000_0010);

        // Immediate forms
        applyStimulus(32'h3C08_1234, 32'h300);
        tick();
        checkOutput("lui_imm", imm_out, 32'h1234_0000);
        checkOutput("lui_aluop", {28'd0, alu_op_out}, 32'd8);
        checkOutput("lui_alusrc", {31'd0, alu_src_out}, 32'd1);
        checkOutput("lui_dest", {27'd0, dest_addr_out}, 32'd8);
        applyStimulus(32'h3409_8001, 32'h304);
        tick();
        checkOutput("ori_imm", imm_out, 32'h0000_8001);
        checkOutput("ori_aluop", {28'd0, alu_op_out}, 32'd3);

        // jr $5 jumps to register contents
        applyStimulus(32'h00A0_0008, 32'h400);
        checkOutput("jr_pcsel", {31'd0, PC_mux_sel}, 32'd1);
        checkOutput("jr_pcjump", PC_jump, 32'h1234_5678);
        tick();
        checkOutput("jr_regwrite", {31'd0, reg_write_out}, 32'd0);

        // Writes to $0 never stick or bypass
        writeback(1'b1, 5'd0, 32'hFFFF_FFFF);
        applyStimulus(32'h0000_3825, 32'h500);
        tick();
        checkOutput("r0_bypass_rs", rs_data_out, 32'd0);
        writeback(1'b0, 5'd0, 32'd0);
        applyStimulus(32'h0000_3825, 32'h504);
        tick();
        checkOutput("r0_stored_rs", rs_data_out, 32'd0);
        checkOutput("or_aluop", {28'd0, alu_op_out}, 32'd3);

        // Reset clears registers and ignores a coincident writeback
        rst = 1'b1;
        writeback(1'b1, 5'd9, 32'h0000_DEAD);
        applyStimulus(32'h0000_0000, 32'h0);
        tick();
        rst = 1'b0;
        writeback(1'b0, 5'd0, 32'd0);
        applyStimulus(32'h0125_1820, 32'h600);
        tick();
        checkOutput("rst_reg9", rs_data_out, 32'd0);
        checkOutput("rst_reg5", rt_data_out, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
